// File: rtl/frame_stream_pkg.sv
// frame_stream_pkg: shared types and constants for the frame read sequencer
// Provides the sequencer state enum, default raster size and RGB444 colour-bar palette.
package frame_stream_pkg;
    typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;
    localparam int H_RES_DEF = 320;
    localparam int V_RES_DEF = 240;
    localparam int FRAME_PIX = H_RES_DEF * V_RES_DEF;
    localparam logic [11:0] RGB_WHITE   = 12'hFFF;
    localparam logic [11:0] RGB_YELLOW  = 12'hFF0;
    localparam logic [11:0] RGB_CYAN    = 12'h0FF;
    localparam logic [11:0] RGB_GREEN   = 12'h0F0;
    localparam logic [11:0] RGB_MAGENTA = 12'hF0F;
    localparam logic [11:0] RGB_RED     = 12'hF00;
    localparam logic [11:0] RGB_BLUE    = 12'h00F;
    localparam logic [11:0] RGB_BLACK   = 12'h000;
    function automatic logic [11:0] bar_colour(input logic [2:0] bar);
        return bar[2] ? (bar[1] ? (bar[0] ? RGB_BLACK : RGB_BLUE) : (bar[0] ? RGB_RED : RGB_MAGENTA))
                      : (bar[1] ? (bar[0] ? RGB_GREEN : RGB_CYAN) : (bar[0] ? RGB_YELLOW : RGB_WHITE));
    endfunction
endpackage

// File: rtl/frame_stream_ctrl_fifo.sv
// stream_skid_fifo: 2-entry skid FIFO absorbing the frame-buffer read latency
// Ports: clk, reset_n (async active-low), flush (sync clear), push/din, pop/dout (head), count (0..2).
module stream_skid_fifo #(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);
    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         rd_q, rd_d, wr_q, wr_d;
    logic [1:0]   cnt_q, cnt_d;
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_q] = din;
        wr_d  = flush ? 1'b0 : wr_q ^ push;
        rd_d  = flush ? 1'b0 : rd_q ^ pop;
        cnt_d = flush ? 2'd0 : cnt_q + {1'b0, push} - {1'b0, pop};
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q <= '{default: '0};
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end
    assign dout  = mem_q[rd_q];
    assign count = cnt_q;
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(push && !pop && !flush && cnt_q == 2'd2));
    a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(pop && cnt_q == 2'd0));
endmodule

// File: rtl/frame_stream_ctrl.sv
// frame_stream_ctrl: raster read sequencer feeding an Avalon-ST sink through a 2-entry skid FIFO
// Ports: clk, reset_n (async active-low), resync (sync restart), mode_in -> mode_out (latched per frame),
//   rd_addr/rd_data (frame buffer, 1-cycle latency), src_* (Avalon-ST source), frame_done, frame_count.
// Option FRAME_STREAM_CTRL_TESTPAT_EN: all-ones frame mode replaces pixels with 8 vertical colour bars.
module frame_stream_ctrl
    import frame_stream_pkg::*;
#(
    parameter int H_RES  = H_RES_DEF,
    parameter int V_RES  = V_RES_DEF,
    parameter int ADDR_W = 17,
    parameter int PIX_W  = 12,
    parameter int MODE_W = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              resync,
    input  logic [MODE_W-1:0] mode_in,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic [PIX_W-1:0]  src_data,
    output logic              src_valid,
    input  logic              src_ready,
    output logic              src_sop,
    output logic              src_eop,
    output logic [MODE_W-1:0] mode_out,
    output logic              frame_done,
    output logic [15:0]       frame_count
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(H_RES * V_RES - 1);
    state_t              state_q, state_d;
    logic                stream, issue, pop;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                inflight_q, inflight_d, sop_tag_q, sop_tag_d, eop_tag_q, eop_tag_d;
    logic [MODE_W-1:0]   mode_q, mode_d;
    logic                frame_done_q, frame_done_d;
    logic [15:0]         frame_count_q, frame_count_d;
    logic [1:0]          fifo_count;
    logic [PIX_W+1:0]    head;
    logic [PIX_W-1:0]    head_data;
    logic                head_sop, head_eop;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end
    always_comb begin
        state_d = resync ? IDLE : (state_q == IDLE ? STREAM : state_q);
    end
    always_comb begin
        stream = (state_q == STREAM);
    end
    stream_skid_fifo #(.W(PIX_W + 2)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (resync),
        .push    (inflight_q),
        .pop     (pop),
        .din     ({sop_tag_q, eop_tag_q, rd_data}),
        .dout    (head),
        .count   (fifo_count)
    );
    assign head_sop  = head[PIX_W+1];
    assign head_eop  = head[PIX_W];
    assign head_data = head[PIX_W-1:0];
    assign src_valid = (fifo_count != 2'd0);
    assign pop       = src_valid & src_ready;
    // Occupancy counts the read still in flight so a stalled sink never overflows the FIFO.
    assign issue = stream && (({1'b0, fifo_count} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop}));
    always_comb begin
        rd_addr_d     = resync ? '0 : (issue ? (rd_addr_q == LAST ? '0 : rd_addr_q + 1'b1) : rd_addr_q);
        inflight_d    = issue & ~resync;
        sop_tag_d     = (rd_addr_q == '0);
        eop_tag_d     = (rd_addr_q == LAST);
        mode_d        = (pop & head_sop) ? mode_in : mode_q;
        frame_done_d  = pop & head_eop;
        frame_count_d = frame_count_q + {15'd0, pop & head_eop};
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_addr_q     <= '0;
            inflight_q    <= 1'b0;
            sop_tag_q     <= 1'b0;
            eop_tag_q     <= 1'b0;
            mode_q        <= '0;
            frame_done_q  <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            rd_addr_q     <= rd_addr_d;
            inflight_q    <= inflight_d;
            sop_tag_q     <= sop_tag_d;
            eop_tag_q     <= eop_tag_d;
            mode_q        <= mode_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
        end
    end
`ifdef FRAME_STREAM_CTRL_TESTPAT_EN
    localparam int COL_W = $clog2(H_RES);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_RES - 1);
    logic [COL_W-1:0]  col_q, col_d;
    logic [MODE_W-1:0] frame_mode;
    // col_q tracks the column of the FIFO head; the SOP beat takes the mode it is about to latch.
    always_comb begin
        col_d      = resync ? '0 : (pop ? (col_q == COL_LAST ? '0 : col_q + 1'b1) : col_q);
        frame_mode = head_sop ? mode_in : mode_q;
        src_data   = (&frame_mode) ? PIX_W'(bar_colour(3'(col_q / (H_RES / 8)))) : head_data;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) col_q <= '0;
        else          col_q <= col_d;
    end
`else
    assign src_data = head_data;
`endif
    assign rd_addr     = rd_addr_q;
    assign src_sop     = src_valid & head_sop;
    assign src_eop     = src_valid & head_eop;
    assign mode_out    = mode_q;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
endmodule
